// File: rtl/fminmax_reduce_pkg.sv
// Shared FPU definitions for the min/max reduction engine: constants, state encoding, NaN detect.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fminmax_reduce_pkg;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_INF   = 8'hFF;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    // Running extremes of the stream, kept together as one wide register.
    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } fp_pair_t;

    // Quiet and signalling NaNs alike: all-ones exponent, nonzero mantissa.
    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_INF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fminmax_cmp.sv
// Binary32 total-order less-than (sign-magnitude, -0 < +0, infinities as ordinary extremes) plus NaN flag on a.
// Latency: purely combinational.
// Backpressure: not applicable.
module fminmax_cmp
    import fminmax_reduce_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        a_nan
);

    // Opposite signs: the negative one is smaller (this also orders -0 below +0).
    // Same sign: magnitudes compare directly for positives, reversed for negatives.
    always_comb begin
        lt = 1'b0;
        if (a[31] != b[31]) begin
            lt = a[31];
        end else if (a[31]) begin
            lt = (a[30:0] > b[30:0]);
        end else begin
            lt = (a[30:0] < b[30:0]);
        end
    end

    assign a_nan = fp_is_nan(a);

endmodule

// File: rtl/fminmax_reduce.sv
// Streaming binary32 min/max/count/NaN reduction; optional first-occurrence indices under FMINMAX_INDEX_EN.
// Latency: m_valid rises the cycle after the s_last beat is accepted; 1 beat/cycle while accumulating.
// Backpressure: result held while m_ready=0; s_ready=0 in RESULT, one bubble per stream after the handshake.
module fminmax_reduce
    import fminmax_reduce_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_min,
    output logic [31:0]      m_max,
    output logic             m_nan,
    output logic [CNT_W-1:0] m_count
`ifdef FMINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] m_min_idx,
    output logic [CNT_W-1:0] m_max_idx
`endif
);

    state_t           state;
    state_t           state_nxt;
    fp_pair_t         acc;
    logic             nan_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic clear;
    logic data_nan;
    logic max_nan;
    logic seen;
    logic lt_min;
    logic gt_max;
    logic take_min;
    logic take_max;
    logic cnt_sat;

    // Min path: is the operand below the running minimum?
    fminmax_cmp u_cmp_min (
        .a     (s_data),
        .b     (acc.lo),
        .lt    (lt_min),
        .a_nan (data_nan)
    );

    // Max path, operands swapped: is the running maximum below the operand?
    fminmax_cmp u_cmp_max (
        .a     (acc.hi),
        .b     (s_data),
        .lt    (gt_max),
        .a_nan (max_nan)
    );

    // The max register holds the canonical NaN exactly until the first non-NaN
    // operand of the stream loads it, so it doubles as the "seen" flag.
    assign seen     = !max_nan;
    assign accept   = s_valid && s_ready;
    assign clear    = m_valid && m_ready;
    assign take_min = accept && !data_nan && (!seen || lt_min);
    assign take_max = accept && !data_nan && (!seen || gt_max);
    assign cnt_sat  = &cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; s_ready/m_valid depend on state only.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            ACCUM: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = ACCUM;
                end
            end
        endcase
    end

    // Accumulators: cleared on result handshake, updated on each accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc.lo <= FP_CANON_NAN;
            acc.hi <= FP_CANON_NAN;
            nan_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (clear) begin
            acc.lo <= FP_CANON_NAN;
            acc.hi <= FP_CANON_NAN;
            nan_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            if (take_min) begin
                acc.lo <= s_data;
            end
            if (take_max) begin
                acc.hi <= s_data;
            end
            if (data_nan) begin
                nan_q <= 1'b1;
            end
            if (!cnt_sat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef FMINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx_q;
    logic [CNT_W-1:0] max_idx_q;

    // Index of the current beat is the pre-increment count, so it saturates with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else if (clear) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            if (take_min) begin
                min_idx_q <= cnt_q;
            end
            if (take_max) begin
                max_idx_q <= cnt_q;
            end
        end
    end

    assign m_min_idx = min_idx_q;
    assign m_max_idx = max_idx_q;
`endif

    assign m_min   = acc.lo;
    assign m_max   = acc.hi;
    assign m_nan   = nan_q;
    assign m_count = cnt_q;

endmodule

// File: tb/tb_fminmax_reduce.sv
// Self-checking bench for fminmax_reduce: scoreboard of expected results, compared on each result handshake.
// Latency: checks m_valid the cycle after the last beat.
// Backpressure: exercises held results under m_ready=0 and mid-stream reset.
module tb_fminmax_reduce;

    localparam int          CNT_W = 4;
    localparam logic [31:0] CNAN  = 32'h7FC00000;

    logic             clk     = 1'b0;
    logic             rstn    = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [31:0]      s_data  = 32'd0;
    logic             s_last  = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [31:0]      m_min;
    logic [31:0]      m_max;
    logic             m_nan;
    logic [CNT_W-1:0] m_count;
`ifdef FMINMAX_INDEX_EN
    logic [CNT_W-1:0] m_min_idx;
    logic [CNT_W-1:0] m_max_idx;
`endif

    typedef struct {
        logic [31:0]      mn;
        logic [31:0]      mx;
        logic             nan;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] mn_i;
        logic [CNT_W-1:0] mx_i;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim[$];
    logic [31:0] pick[13];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fminmax_reduce #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_min     (m_min),
        .m_max     (m_max),
        .m_nan     (m_nan),
        .m_count   (m_count)
`ifdef FMINMAX_INDEX_EN
        ,
        .m_min_idx (m_min_idx),
        .m_max_idx (m_max_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key for non-NaN binary32 values (-0 sorts below +0).
    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int v);
        int lim;
        lim = (1 << CNT_W) - 1;
        return (v > lim) ? CNT_W'(lim) : CNT_W'(v);
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic any;
        any    = 1'b0;
        e.mn   = CNAN;
        e.mx   = CNAN;
        e.nan  = 1'b0;
        e.mn_i = '0;
        e.mx_i = '0;
        e.cnt  = sat(stim.size());
        foreach (stim[i]) begin
            if (is_nan(stim[i])) begin
                e.nan = 1'b1;
            end else if (!any) begin
                any    = 1'b1;
                e.mn   = stim[i];
                e.mx   = stim[i];
                e.mn_i = sat(i);
                e.mx_i = sat(i);
            end else begin
                if (okey(stim[i]) < okey(e.mn)) begin
                    e.mn   = stim[i];
                    e.mn_i = sat(i);
                end
                if (okey(stim[i]) > okey(e.mx)) begin
                    e.mx   = stim[i];
                    e.mx_i = sat(i);
                end
            end
        end
        return e;
    endfunction

    // Drive every beat of stim back-to-back and push the expected result.
    task automatic run_stream(input string tag);
        exp_q.push_back(model());
        chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
        foreach (stim[i]) begin
            s_valid = 1'b1;
            s_data  = stim[i];
            s_last  = (i == stim.size() - 1);
            @(posedge clk);
            #1;
            if (i != stim.size() - 1) begin
                chk({tag, ".early_valid"}, 32'(m_valid), 32'd0);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait (bounded) for the result, compare against the scoreboard, optionally stall, then handshake.
    task automatic get_result(input string tag, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd0);
        e = exp_q.pop_front();
        if (m_valid) begin
            chk({tag, ".min"}, m_min, e.mn);
            chk({tag, ".max"}, m_max, e.mx);
            chk({tag, ".nan"}, 32'(m_nan), 32'(e.nan));
            chk({tag, ".count"}, 32'(m_count), 32'(e.cnt));
`ifdef FMINMAX_INDEX_EN
            chk({tag, ".min_idx"}, 32'(m_min_idx), 32'(e.mn_i));
            chk({tag, ".max_idx"}, 32'(m_max_idx), 32'(e.mx_i));
`endif
            for (int h = 0; h < hold; h++) begin
                s_valid = 1'b1;
                s_data  = 32'hC1000000;
                s_last  = 1'b1;
                @(posedge clk);
                #1;
                chk({tag, ".hold_valid"}, 32'(m_valid), 32'd1);
                chk({tag, ".hold_ready"}, 32'(s_ready), 32'd0);
                chk({tag, ".hold_min"}, m_min, e.mn);
                chk({tag, ".hold_count"}, 32'(m_count), 32'(e.cnt));
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            chk({tag, ".post_valid"}, 32'(m_valid), 32'd0);
            chk({tag, ".post_ready"}, 32'(s_ready), 32'd1);
            chk({tag, ".post_count"}, 32'(m_count), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, ".min"}, m_min, CNAN);
        chk({tag, ".max"}, m_max, CNAN);
        chk({tag, ".nan"}, 32'(m_nan), 32'd0);
        chk({tag, ".count"}, 32'(m_count), 32'd0);
`ifdef FMINMAX_INDEX_EN
        chk({tag, ".min_idx"}, 32'(m_min_idx), 32'd0);
        chk({tag, ".max_idx"}, 32'(m_max_idx), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        pick = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
                 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h40490FDB,
                 32'hC0490FDB, 32'h00000001, 32'h80000001};

        #2 rstn = 1'b0;
        #1 chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst.s_ready", 32'(s_ready), 32'd1);
        chk_reset_vals("rst_rel");

        stim = '{32'h3F800000, 32'hC0000000, 32'h40600000};
        run_stream("basic");
        get_result("basic", 0);

        stim = '{32'h7FC00001, 32'h3F800000};
        run_stream("nan_first");
        get_result("nan_first", 0);

        stim = '{32'h7F800001};
        run_stream("all_nan");
        get_result("all_nan", 0);

        stim = '{32'h00000000, 32'h80000000};
        run_stream("zeros");
        get_result("zeros", 0);

        stim = '{32'h80000000, 32'h00000000, 32'h80000000};
        run_stream("zeros_tie");
        get_result("zeros_tie", 0);

        stim = '{32'hFF800000, 32'h7F800000};
        run_stream("infs");
        get_result("infs", 0);

        stim = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000};
        run_stream("hold");
        get_result("hold", 5);

        stim = '{32'h40400000};
        run_stream("after_hold");
        get_result("after_hold", 0);

        stim.delete();
        for (int i = 0; i < 18; i++) begin
            stim.push_back(32'h3F800000 + 32'(i));
        end
        run_stream("saturate");
        get_result("saturate", 0);

        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 12);
            stim.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    stim.push_back($urandom);
                end else begin
                    stim.push_back(pick[$urandom_range(0, 12)]);
                end
            end
            run_stream($sformatf("rand%0d", r));
            get_result($sformatf("rand%0d", r), 0);
        end

        // Two of four beats, then reset: partial stream must vanish.
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 32'h7FC00001;
        @(posedge clk);
        #1;
        s_data  = 32'h3F800000;
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        s_valid = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst.no_valid", 32'(m_valid), 32'd0);
        end

        stim = '{32'h40000000};
        run_stream("fresh");
        get_result("fresh", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fminmax_reduce.md
# fminmax_reduce

Streaming single-precision min/max reduction engine in the FPU cluster. It accepts IEEE-754 binary32 operands one per cycle over a valid/ready stream, with a `last` marker, and keeps a running minimum, maximum, element count and NaN-seen flag. At the end of each stream it presents the reduced result on a held output handshake. Ordering follows the FPU compare unit: NaNs are unordered and ±0 compare equal. Zero ties are broken with −0 < +0, as in RISC-V fmin/fmax.

## Interface
- `CNT_W`, default 16: width of element counter.
- `clk` input 1: clock, all state on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `s_valid` input 1: operand beat valid.
- `s_ready` output 1: engine accepts a beat this cycle.
- `s_data` input 32: binary32 operand.
- `s_last` input 1: final beat of current stream.
- `m_valid` output 1: result valid.
- `m_ready` input 1: result consumer ready.
- `m_min` output 32: reduced minimum.
- `m_max` output 32: reduced maximum.
- `m_nan` output 1: at least one NaN operand (quiet or signalling) seen in stream.
- `m_count` output CNT_W: beats accepted in stream, saturating.
- `m_min_idx`, `m_max_idx` output CNT_W: beat index of min/max (only with FMINMAX_INDEX_EN).

## Operation
- Two states: ACCUM, RESULT. Reset → ACCUM.
- ACCUM: `s_ready`=1, `m_valid`=0. Beat accepted when `s_valid && s_ready`.
  - NaN operand (exp=0xFF, mantissa≠0): sets nan flag, increments count, does not touch min/max.
  - Non-NaN operand, no non-NaN seen yet in stream: loads min and max directly.
  - Otherwise: min ← operand if operand < min; max ← operand if operand > max. Equal values, including ±0 vs ±0 of same sign, leave the register unchanged.
  - Ordering is a total order on non-NaN values: sign-magnitude compare, with −0 < +0, +inf/−inf as ordinary extremes.
  - Accepted beat with `s_last`=1 → RESULT.
- RESULT: `s_ready`=0, `m_valid`=1, outputs stable. When `m_ready`=1, go to ACCUM and clear accumulators (min/max=0x7FC00000, nan=0, count=0, "seen" flag=0).
- All-NaN stream: `m_min`=`m_max`=0x7FC00000 (canonical NaN), `m_nan`=1.
- Counter saturates at 2^CNT_W−1; it does not wrap. Index outputs also saturate.
- `s_valid` with `s_data` in RESULT is ignored (not accepted). No simultaneous accept + result.

## Timing
- Reset values: `s_ready`=1 once `rstn` is high, `m_valid`=0, `m_min`=`m_max`=0x7FC00000, `m_nan`=0, `m_count`=0, indices 0.
- Throughput: 1 beat/cycle in ACCUM.
- Latency: `m_valid` rises the cycle after the `s_last` beat is accepted. Result includes that beat.
- Result held indefinitely under backpressure. Next stream's first beat is accepted the cycle after the `m_valid && m_ready` handshake (one bubble per stream).
- `s_ready` is a register-decoded function of state only, with no combinational path from `s_valid`/`m_ready`.
- `rstn` asserted mid-stream or mid-result: immediate return to reset values. The partial stream is discarded with no result.

## Configuration
- `FMINMAX_INDEX_EN` defined: `m_min_idx`/`m_max_idx` ports exist and are registered. Each gives the 0-based beat index of the first occurrence of the reported value. They are 0 for an all-NaN stream.
- Not defined: index ports and registers are absent. All other behaviour is identical.

## Structure
- Shared FPU package: constants `FP_CANON_NAN`=32'h7FC00000 and `FP_EXP_INF`=8'hFF; NaN-detect and state enum (`ACCUM`, `RESULT`) typedefs.
- One combinational sub-module `fminmax_cmp`: inputs a, b (32). Outputs `lt` (total order incl. −0<+0) and `a_nan`. It is instantiated twice (min path, max path with operands swapped).
- Top level holds the FSM, accumulators, counter and optional index logic.

## Test plan
- Stream 0x3F800000, 0xC0000000, 0x40600000(last) → min 0xC0000000, max 0x40600000, count 3, nan 0, min_idx 1, max_idx 2.
- Stream 0x7FC00001, 0x3F800000(last) → min=max=0x3F800000, nan 1, count 2.
- Single beat 0x7F800001(last) → min=max=0x7FC00000, nan 1, count 1.
- Stream 0x00000000, 0x80000000(last) → min 0x80000000, max 0x00000000. Stream 0xFF800000, 0x7F800000(last) → min −inf, max +inf.
- Hold `m_ready`=0 for 5 cycles after result → outputs constant, `s_ready`=0, `s_valid` beats not consumed. Release → next stream's accumulators start clean.
- Drop `rstn` after 2 of 4 beats → all outputs return to reset values, no `m_valid`. A fresh 1-beat stream 0x40000000(last) → min=max=0x40000000, count 1.
